delta_cycle_scheduler: RTL and testbench
========================================

// Module: delta_cycle_scheduler
//
// PURPOSE
// Hardware model of the simulator active-region loop. It sequences N evaluation
// processes (always_comb bodies, continuous-assign drivers) over one time step.
// Processes raise trigger pulses when an input in their sensitivity set changes.
// The scheduler grants one pending process per cycle, round-robin, until the
// pending set is empty (settled), or until an iteration limit flags oscillation.
// A re-trigger raised during a process's own grant re-runs that process. This
// gives the "always_comb runs twice" settling behaviour in synthesisable form.
//
// PARAMETERS
// N_PROC    4   number of evaluation processes (>=2)
// MAX_ITER  8   max grants per time step before oscillation is declared (>=1)
// ID_W      $clog2(N_PROC)      width of grant_id
// ITER_W    $clog2(MAX_ITER+1)  width of iter_cnt
//
// PORTS
// clk       in   1         clock, rising edge
// rst       in   1         asynchronous reset, active-high
// start     in   1         begin a time step; accepted only in IDLE or OSC
// trig      in   N_PROC    per-process trigger pulse; sets pending bit
// grant     out  N_PROC    one-hot grant to evaluate; all zero when no grant
// grant_id  out  ID_W      binary index of grant; 0 when grant==0
// busy      out  1         high in EVAL
// done      out  1         one-cycle pulse: time step settled
// osc       out  1         sticky: MAX_ITER reached with work still pending
// iter_cnt  out  ITER_W    grants issued in the current time step
//
// BEHAVIOUR
// - Reset (async): state=IDLE, pending=0, rr_ptr=0, iter_cnt=0. All outputs 0.
// - pending[i] <= (pending[i] & ~grant[i]) | trig[i]. trig wins over clear.
//   Triggers accumulate in every state, including IDLE and DONE.
// - States: IDLE, EVAL, DONE, OSC (enum sched_state_t).
//   IDLE: grant=0. start -> EVAL, iter_cnt<=0.
//   EVAL: busy=1.
//     If pending==0 -> DONE.
//     Else if iter_cnt==MAX_ITER -> OSC.
//     Else grant=rr_pick(pending,rr_ptr) (combinational). iter_cnt++.
//     rr_ptr <= grant_id+1 (mod N_PROC).
//   DONE: done=1 for exactly this cycle; grant=0 -> IDLE.
//     Pending left over from a trig in DONE is served on the next start.
//   OSC: osc=1, grant=0, busy=0; iter_cnt holds MAX_ITER.
//     start -> IDLE, clears pending, osc, and iter_cnt.
// - start in EVAL or DONE is ignored. start with rst is ignored.
// - Latency: start accepted at edge t. First grant visible in cycle t+1.
//   A settle with k grants gives done at cycle t+1+k.
// - Round-robin: search starts at rr_ptr and wraps N_PROC-1 -> 0.
//   rr_ptr=0 after reset.
// - iter_cnt never exceeds MAX_ITER; no wrap.
// - A grant and a trig to the same process in the same cycle keep it pending.
//   It is re-granted after the other pending processes ahead of it in RR order.
// - rst mid-EVAL drops all pending and the grant immediately. No done pulse.
//
// STRUCTURE
// - sched_pkg: sched_state_t enum; onehot_to_bin function.
// - Sub-module rr_arbiter #(N): inputs req, ptr; outputs one-hot gnt and gnt_id.
//   Purely combinational, instanced once.
// - Top level holds the FSM, the pending register, rr_ptr, and iter_cnt.
//
// TESTING  (N_PROC=4, MAX_ITER=8)
// 1. rst pulse mid-cycle -> all outputs 0 asynchronously; state IDLE after release.
// 2. trig=0101 in IDLE, start -> grant 0001 then 0100.
//    done one cycle later; iter_cnt=2.
// 3. Self re-trigger: pending=0001, trig[0] raised during its grant.
//    -> grant 0001 twice; done; iter_cnt=2.
// 4. Fairness: pending=1111, each grantee re-triggers once.
//    -> grant order 0,1,2,3,0,1,2,3; done; iter_cnt=8.
// 5. Oscillation: trig[1] on every grant[1].
//    -> 8 grants, then osc=1, busy=0.
//    start -> osc=0, pending=0, IDLE.
// 6. start during EVAL ignored (iter_cnt unaffected).
//    trig[2] in DONE cycle -> pending[2]=1 in IDLE, granted after next start.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared types and helpers for the delta-cycle scheduler: FSM state encoding
// and a one-hot to binary index conversion.
package sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2,
    ST_OSC  = 2'd3
  } sched_state_t;

  localparam int unsigned OH_MAX_W = 32;

  // Index of the set bit in a one-hot vector (0 when the vector is all zero).
  function automatic int unsigned onehot_to_bin(input logic [OH_MAX_W-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < OH_MAX_W; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after
// i_ptr, wrapping from N-1 back to 0.
module rr_arbiter
  import sched_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [N-1:0]    o_gnt,
  output logic [ID_W-1:0] o_gnt_id
);

  logic [ID_W:0] w_idx;
  logic          w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = {1'b0, i_ptr} + (ID_W+1)'(k);
      if (w_idx >= (ID_W+1)'(N)) w_idx = w_idx - (ID_W+1)'(N);
      if (!w_found && i_req[w_idx[ID_W-1:0]]) begin
        o_gnt[w_idx[ID_W-1:0]] = 1'b1;
        w_found                = 1'b1;
      end
    end
  end

  assign o_gnt_id = ID_W'(onehot_to_bin(OH_MAX_W'(o_gnt)));

endmodule

// File: rtl/delta_cycle_scheduler.sv
// Active-region loop: grants pending evaluation processes one per cycle in
// round-robin order until the pending set drains or the iteration cap is hit.
module delta_cycle_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned N_PROC   = 4,
  parameter int unsigned MAX_ITER = 8,
  parameter int unsigned ID_W     = $clog2(N_PROC),
  parameter int unsigned ITER_W   = $clog2(MAX_ITER + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [N_PROC-1:0] i_trig,
  output logic [N_PROC-1:0] o_grant,
  output logic [ID_W-1:0]   o_grant_id,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_osc,
  output logic [ITER_W-1:0] o_iter_cnt
);

  sched_state_t      r_state;
  sched_state_t      w_state_nxt;
  logic [N_PROC-1:0] r_pending;
  logic [N_PROC-1:0] w_pending_after;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   w_rr_ptr_nxt;
  logic [ITER_W-1:0] r_iter_cnt;
  logic [N_PROC-1:0] w_arb_gnt;
  logic [ID_W-1:0]   w_arb_id;
  logic              w_grant_en;
  logic              w_restart;

  rr_arbiter #(
    .N    (N_PROC),
    .ID_W (ID_W)
  ) u_rr_arbiter (
    .i_req    (r_pending),
    .i_ptr    (r_rr_ptr),
    .o_gnt    (w_arb_gnt),
    .o_gnt_id (w_arb_id)
  );

  // Pending set as it would stand after the arbiter's pick is served; a
  // same-cycle trigger keeps the grantee pending.
  assign w_pending_after = (r_pending & ~w_arb_gnt) | i_trig;

  // Next-state and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_osc       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_nxt = ST_EVAL;
      end
      ST_EVAL: begin
        o_busy = 1'b1;
        if (r_pending == '0) begin
          w_state_nxt = ST_DONE;
        end else if (r_iter_cnt == ITER_W'(MAX_ITER)) begin
          w_state_nxt = ST_OSC;
        end else begin
          w_grant_en = 1'b1;
          // Settle is seen at the edge of the final grant so done follows it directly.
          if (w_pending_after == '0) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_OSC: begin
        o_osc = 1'b1;
        if (i_start) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_grant    = w_grant_en ? w_arb_gnt : '0;
  assign o_grant_id = w_grant_en ? w_arb_id : '0;
  assign o_iter_cnt = r_iter_cnt;

  assign w_restart    = i_start && (r_state == ST_IDLE || r_state == ST_OSC);
  assign w_rr_ptr_nxt = (w_arb_id == ID_W'(N_PROC - 1)) ? '0 : w_arb_id + ID_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Triggers accumulate in every state; leaving OSC discards the stale set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending <= '0;
    end else if (r_state == ST_OSC && i_start) begin
      r_pending <= i_trig;
    end else begin
      r_pending <= (r_pending & ~o_grant) | i_trig;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_ptr   <= '0;
      r_iter_cnt <= '0;
    end else begin
      if (w_grant_en) begin
        r_rr_ptr   <= w_rr_ptr_nxt;
        r_iter_cnt <= r_iter_cnt + ITER_W'(1);
      end else if (w_restart) begin
        r_iter_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_delta_cycle_scheduler.sv
// Scoreboard bench: a list-level reference model predicts each time step's
// grant/done/osc events; a monitor pops and compares as the DUT presents them.
module tb_delta_cycle_scheduler;

  localparam int NP   = 4;
  localparam int MAXI = 8;
  localparam int K_GNT  = 0;
  localparam int K_DONE = 1;
  localparam int K_OSC  = 2;

  typedef struct {
    int kind;
    int id;
    int iter;
  } exp_t;

  logic          clk;
  logic          i_rst;
  logic          i_start;
  logic [NP-1:0] i_trig;
  logic [NP-1:0] o_grant;
  logic [1:0]    o_grant_id;
  logic          o_busy;
  logic          o_done;
  logic          o_osc;
  logic [3:0]    o_iter_cnt;

  exp_t     q[$];
  int       n_chk;
  int       n_fail;
  bit       mon_en;
  logic     prev_osc;
  logic [NP-1:0] m_pend;
  int       m_ptr;

  delta_cycle_scheduler dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_trig     (i_trig),
    .o_grant    (o_grant),
    .o_grant_id (o_grant_id),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_osc      (o_osc),
    .o_iter_cnt (o_iter_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: compare every presented event against the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (o_grant != '0 || o_done || (o_osc && !prev_osc)) begin
        if (q.size() == 0) begin
          check("sb_unexpected_event", 1, 0);
        end else begin
          e = q.pop_front();
          if (o_grant != '0) begin
            check("event_kind_grant", K_GNT, e.kind);
            check("grant_onehot", int'(o_grant), 1 << e.id);
            check("grant_id", int'(o_grant_id), e.id);
            check("grant_iter_cnt", int'(o_iter_cnt), e.iter);
            check("grant_busy", int'(o_busy), 1);
          end else if (o_done) begin
            check("event_kind_done", K_DONE, e.kind);
            check("done_iter_cnt", int'(o_iter_cnt), e.iter);
            check("done_busy", int'(o_busy), 0);
          end else begin
            check("event_kind_osc", K_OSC, e.kind);
            check("osc_iter_cnt", int'(o_iter_cnt), e.iter);
            check("osc_busy", int'(o_busy), 0);
          end
        end
      end
    end
    prev_osc = o_osc;
  end

  // One time step: preload triggers, predict the event list, start, and
  // re-trigger each process up to its budget whenever it is granted.
  task automatic run_step(input logic [NP-1:0] pre, input int r0, input int r1,
                          input int r2, input int r3, input logic [NP-1:0] dtrig,
                          input bit noise);
    int       left[NP];
    int       mleft[NP];
    logic [NP-1:0] p;
    int       cnt;
    int       sel;
    bit       fin;
    bit       osc_exp;
    bit       stop;
    int       cyc;
    left  = '{r0, r1, r2, r3};
    mleft = left;

    @(negedge clk);
    i_trig  = pre;
    i_start = 1'b0;
    m_pend  = m_pend | pre;

    p = m_pend; cnt = 0; osc_exp = 1'b0; stop = 1'b0;
    for (int s = 0; s <= MAXI + 1 && !stop; s++) begin
      if (p == '0) begin
        q.push_back('{K_DONE, 0, cnt});
        stop = 1'b1;
      end else if (cnt == MAXI) begin
        q.push_back('{K_OSC, 0, MAXI});
        osc_exp = 1'b1;
        stop    = 1'b1;
      end else begin
        sel = 0;
        for (int k = NP - 1; k >= 0; k--) if (p[(m_ptr + k) % NP]) sel = (m_ptr + k) % NP;
        q.push_back('{K_GNT, sel, cnt});
        p[sel] = 1'b0;
        if (mleft[sel] > 0) begin
          mleft[sel]--;
          p[sel] = 1'b1;
        end
        m_ptr = (sel + 1) % NP;
        cnt++;
      end
    end

    @(negedge clk);
    i_trig  = '0;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;

    fin = 1'b0;
    cyc = 0;
    while (!fin && cyc < 60) begin
      i_trig  = '0;
      i_start = 1'b0;
      if (o_grant != '0) begin
        if (left[o_grant_id] > 0) begin
          i_trig[o_grant_id] = 1'b1;
          left[o_grant_id]--;
        end
        // Starts while evaluating must be ignored.
        if (noise && !osc_exp && $urandom_range(0, 1) == 1) i_start = 1'b1;
      end
      if (o_done) begin
        i_trig = dtrig;
        fin    = 1'b1;
      end
      if (o_osc) fin = 1'b1;
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) check("step_timeout", 0, 1);

    if (o_osc) begin
      @(negedge clk);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      check("osc_clear_osc", int'(o_osc), 0);
      check("osc_clear_busy", int'(o_busy), 0);
      check("osc_clear_iter", int'(o_iter_cnt), 0);
      m_pend = '0;
    end else begin
      m_pend = osc_exp ? '0 : dtrig;
    end
  endtask

  initial begin
    int r[NP];
    logic [NP-1:0] pre;
    logic [NP-1:0] dt;
    n_chk    = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    prev_osc = 1'b0;
    m_pend   = '0;
    m_ptr    = 0;
    i_rst    = 1'b1;
    i_start  = 1'b0;
    i_trig   = '0;

    repeat (2) @(negedge clk);
    check("rst_grant", int'(o_grant), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_osc", int'(o_osc), 0);
    check("rst_iter", int'(o_iter_cnt), 0);
    i_rst = 1'b0;

    // Asynchronous reset while evaluating.
    @(negedge clk);
    i_trig = 4'b0011;
    @(negedge clk);
    i_trig  = '0;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("pre_rst_busy", int'(o_busy), 1);
    check("pre_rst_grant", int'(o_grant), 1);
    @(posedge clk);
    #2 i_rst = 1'b1;
    #1;
    check("async_rst_grant", int'(o_grant), 0);
    check("async_rst_grant_id", int'(o_grant_id), 0);
    check("async_rst_busy", int'(o_busy), 0);
    check("async_rst_done", int'(o_done), 0);
    check("async_rst_iter", int'(o_iter_cnt), 0);
    @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", int'(o_busy), 0);
    check("post_rst_grant", int'(o_grant), 0);
    mon_en = 1'b1;

    run_step(4'b0000, 0, 0, 0, 0, 4'b0000, 1'b0);  // pending dropped by reset
    run_step(4'b1111, 1, 1, 1, 1, 4'b0000, 1'b0);  // fairness, 8 grants
    run_step(4'b0101, 0, 0, 0, 0, 4'b0000, 1'b0);  // two grants
    run_step(4'b0001, 1, 0, 0, 0, 4'b0000, 1'b0);  // self re-trigger
    run_step(4'b0010, 0, 99, 0, 0, 4'b0000, 1'b0); // oscillation
    run_step(4'b0000, 0, 0, 0, 0, 4'b0000, 1'b0);  // pending cleared by osc exit
    run_step(4'b0011, 0, 1, 0, 0, 4'b0100, 1'b1);  // start noise, trig in DONE
    run_step(4'b0000, 0, 0, 0, 0, 4'b0000, 1'b0);  // leftover served

    for (int t = 0; t < 40; t++) begin
      pre = 4'($urandom_range(0, 15));
      for (int i = 0; i < NP; i++) r[i] = $urandom_range(0, 2);
      dt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      run_step(pre, r[0], r[1], r[2], r[3], dt, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    i_trig = '0;
    repeat (3) @(negedge clk);
    check("sb_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
